// File: rtl/aes_key_sched_pkg.sv
// Shared AES key-schedule definitions: key length encoding, Nk/Nr lookup,
// the forward S-box and GF(2^8) doubling.
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128 = 2'd0,
        KEY_192 = 2'd1,
        KEY_256 = 2'd2,
        KEY_ILL = 2'd3
    } key_len_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [3:0] nk_of(key_len_t k);
        case (k)
            KEY_128: return 4'd4;
            KEY_192: return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(key_len_t k);
        case (k)
            KEY_128: return 4'd10;
            KEY_192: return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_key_sched_if.sv
// Key-load handshake and round-key read port between the round datapath
// (master) and the key schedule (slave).
interface aes_key_sched_if;
    logic        key_valid;
    logic [31:0] key_word;
    logic        key_ready;
    logic [3:0]  rd_round;
    logic [1:0]  rd_word;
    logic [31:0] rd_data;

    modport master (
        output key_valid, key_word, rd_round, rd_word,
        input  key_ready, rd_data
    );

    modport slave (
        input  key_valid, key_word, rd_round, rd_word,
        output key_ready, rd_data
    );
endinterface

// File: rtl/aes_key_sched_sub_word.sv
// SubWord: independent S-box substitution of each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] subbed
);
    assign subbed = {sbox(word[31:24]), sbox(word[23:16]),
                     sbox(word[15:8]),  sbox(word[7:0])};
endmodule

// File: rtl/aes_key_sched.sv
// Word-serial AES-128/192/256 key expansion into a flat word store with a
// random-access round-key read port.
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8,
    parameter int RD_REG = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       key_len,
    aes_key_sched_if.slave   bus,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int DEPTH = 4 * (MAX_NK + 7);
    localparam int IW    = $clog2(DEPTH);
    localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_EXPAND = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state;
    logic [3:0]    nk;
    logic [3:0]    nr;
    logic [IW-1:0] idx;
    logic [2:0]    j;
    logic [7:0]    rc;
    logic          err_q;
    logic [31:0]   store [DEPTH];

    key_len_t      len;
    logic          legal;
    logic          xfer;
    logic          j_wrap;
    logic [IW-1:0] last_idx;
    logic [31:0]   w_prev;
    logic [31:0]   w_back;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   temp;
    logic [31:0]   w_new;
    logic          we;
    logic [31:0]   wdata;
    logic          rd_hit;
    logic [IW-1:0] rd_idx;
    logic [31:0]   rd_comb;

    assign len      = key_len_t'(key_len);
    assign legal    = (len != KEY_ILL) && (nk_of(len) <= MAX_NK_W);
    assign xfer     = (state == S_LOAD) && bus.key_valid;
    assign j_wrap   = ({1'b0, j} == (nk - 4'd1));
    // {nr, 2'b11} == 4*(Nr+1)-1, the index of the final expanded word
    assign last_idx = IW'({nr, 2'b11});
    assign w_prev   = store[idx - IW'(1)];
    assign w_back   = store[idx - IW'(nk)];

    aes_sub_word u_sub (
        .word   (sub_in),
        .subbed (sub_out)
    );

    always_comb begin
        sub_in = w_prev;
        temp   = w_prev;
        if (j == 3'd0) begin
            sub_in = {w_prev[23:0], w_prev[31:24]};
            temp   = sub_out ^ {rc, 24'h0};
        end else if (nk == 4'd8 && j == 3'd4) begin
            temp   = sub_out;
        end
        w_new = w_back ^ temp;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            nk    <= 4'd4;
            nr    <= 4'd10;
            idx   <= '0;
            j     <= '0;
            rc    <= 8'h01;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (start) begin
                if (legal) begin
                    state <= S_LOAD;
                    nk    <= nk_of(len);
                    nr    <= nr_of(len);
                    idx   <= '0;
                    j     <= '0;
                    rc    <= 8'h01;
                end else begin
                    // a rejected start keeps a finished schedule, aborts a live one
                    err_q <= 1'b1;
                    if (state != S_DONE) state <= S_IDLE;
                end
            end else begin
                case (state)
                    S_LOAD: begin
                        if (xfer) begin
                            idx <= idx + IW'(1);
                            if (idx == IW'(nk - 4'd1)) begin
                                state <= S_EXPAND;
                                j     <= '0;
                            end
                        end
                    end
                    S_EXPAND: begin
                        idx <= idx + IW'(1);
                        j   <= j_wrap ? 3'd0 : j + 3'd1;
                        if (j == 3'd0) rc <= xtime(rc);
                        if (idx == last_idx) state <= S_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign we    = !start && (xfer || (state == S_EXPAND));
    assign wdata = (state == S_LOAD) ? bus.key_word : w_new;

    always_ff @(posedge clk) begin
        if (we) store[idx] <= wdata;
    end

    assign rd_hit  = (bus.rd_round <= nr);
    assign rd_idx  = IW'({bus.rd_round, bus.rd_word});
    assign rd_comb = rd_hit ? store[rd_idx] : '0;

    if (RD_REG != 0) begin : g_rd_reg
        logic [31:0] rd_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) rd_q <= '0;
            else       rd_q <= rd_comb;
        end
        assign bus.rd_data = rd_q;
    end else begin : g_rd_comb
        assign bus.rd_data = rd_comb;
    end

    assign bus.key_ready = (state == S_LOAD);
    assign busy          = (state == S_LOAD) || (state == S_EXPAND);
    assign done          = (state == S_DONE);
    assign err           = err_q;

endmodule
